fir_tdm_prog: RTL and testbench
===============================

// Module: fir_tdm_prog
// PURPOSE
//  Parametrised time-multiplexed FIR: NTAPS taps, runtime-programmable coefficients, one shared MAC.
//  Valid/ready stream in and out; saturating/truncating output stage; sat flag per output sample.
//  Next-generation filter block in the lab DSP chain, for low sample-rate streams where a full
//  parallel multiplier tree is wasteful.
// PARAMETERS
//  WW_INPUT   8   input sample width, signed two's complement
//  WW_COEFF   8   coefficient width, signed
//  WW_OUTPUT  8   output sample width, signed
//  NTAPS      15  number of taps (>=2)
//  SHIFT      6   arithmetic right shift applied to accumulator before saturation (coeff frac bits)
// PORTS
//  clk          in   1                   clock, rising edge
//  i_rst_n      in   1                   asynchronous active-low reset
//  i_srst       in   1                   synchronous clear: delay line + FSM only, coefficients kept
//  i_valid      in   1                   input sample valid
//  o_ready      out  1                   block can accept a sample
//  i_data       in   WW_INPUT            input sample
//  o_valid      out  1                   output sample valid
//  i_ready      in   1                   downstream accepts output
//  o_data       out  WW_OUTPUT           filtered, shifted, saturated sample
//  o_sat        out  1                   o_data was clipped (qualified by o_valid)
//  i_coef_we    in   1                   coefficient write strobe
//  i_coef_addr  in   clog2(NTAPS)        coefficient index
//  i_coef_data  in   WW_COEFF            coefficient value
//  o_coef_err   out  1                   1-cycle pulse: write rejected (busy or addr>=NTAPS)
// BEHAVIOUR
//  Reset (async, i_rst_n=0): FSM=IDLE, delay line=0, coefficients=0, acc=0, o_valid=0, o_data=0,
//   o_sat=0, o_coef_err=0, o_ready=1 (combinational from IDLE). Release takes effect next edge.
//  FSM IDLE -> MAC -> OUT -> IDLE. o_ready = (state==IDLE).
//  IDLE: on i_valid&&o_ready edge: tap[0]<=i_data, tap[k]<=tap[k-1], idx<=0, acc<=0, ->MAC.
//  MAC: each cycle acc <= acc + coef[idx]*tap[idx], idx++; after idx==NTAPS-1 -> OUT.
//  OUT entry edge: o_data<=sat(acc>>>SHIFT), o_sat, o_valid<=1; hold all stable while !i_ready.
//   On o_valid&&i_ready edge: o_valid<=0, ->IDLE. Next sample accepted earliest the cycle after.
//  Latency: acceptance edge to o_valid high = NTAPS+1 edges; max throughput 1 sample / NTAPS+2 cycles.
//  Widths: product WW_INPUT+WW_COEFF; acc WW_ACC=WW_INPUT+WW_COEFF+clog2(NTAPS), never overflows.
//   Shift is arithmetic (floor). Saturate to [-2^(WW_OUTPUT-1), 2^(WW_OUTPUT-1)-1]; o_sat=1 if clipped.
//  Coef write: accepted only in IDLE with addr<NTAPS, written at the edge, used by next sample.
//   Write in MAC/OUT or bad addr: dropped, o_coef_err pulses 1 cycle. Write + i_valid in same IDLE
//   cycle: both accepted; the new coefficient applies to that sample.
//  i_srst=1 (sync, priority over all but i_rst_n): delay line=0, acc=0, o_valid=0, FSM=IDLE;
//   in-flight sample discarded; coefficients untouched. Async reset mid-MAC/OUT: same plus coefs=0.
//  i_valid while o_ready=0: ignored (upstream must hold). i_data sampled only on handshake.
// STRUCTURE
//  Shared header fir_defs.vh: FSM state encodings (IDLE/MAC/OUT), clog2 function, WW_ACC macro;
//   reused by all filter variants.
//  Sub-module fir_sat_shift: parametrised (WW_IN, WW_OUT, SHIFT) combinational shift+saturate,
//   outputs data and sat flag; instantiated once on the accumulator.
//  Top holds FSM, tap index counter, delay line, coefficient bank, MAC register, output register.
// TESTING
//  1 Impulse: SHIFT=0, coef[k]=k+1, input 1 then 14 zeros -> o_data 1,2,...,15, then 0; o_sat=0.
//  2 Saturation: all coefs 0x7F, SHIFT=6, input 0x7F steady -> o_data 0x7F, o_sat=1;
//    input 0x80 steady -> o_data 0x80, o_sat=1.
//  3 Backpressure: i_ready low 5 cycles in OUT -> o_data/o_valid stable, o_ready=0, i_valid held,
//    no sample lost or duplicated vs. golden model over 100 random samples.
//  4 Coef write in MAC -> o_coef_err 1-cycle pulse, bank unchanged, current output unchanged;
//    write addr=NTAPS in IDLE -> o_coef_err pulse.
//  5 i_rst_n low mid-MAC -> o_valid=0, o_ready=1 without clock edge; coefs read back 0 (output 0).
//  6 i_srst mid-OUT -> o_valid=0 next edge, later impulse reproduces test-1 response (coefs kept).

Source files
------------

// File: rtl/fir_tdm_prog_pkg.sv
// Shared definitions for the time-multiplexed FIR family: FSM encoding and
// accumulator sizing helpers.
package fir_tdm_prog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_t;

    function automatic int fir_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Wide enough that NTAPS full-scale products can never overflow.
    function automatic int fir_acc_width(input int ww_in, input int ww_coef, input int ntaps);
        return ww_in + ww_coef + fir_clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_sat_shift.sv
// Combinational arithmetic right shift followed by symmetric two's complement
// saturation to WW_OUT bits; sat reports that clipping occurred.
module fir_sat_shift #(
    parameter int WW_IN  = 20,
    parameter int WW_OUT = 8,
    parameter int SHIFT  = 6
) (
    input  logic signed [WW_IN-1:0]  din,
    output logic        [WW_OUT-1:0] dout,
    output logic                     sat
);

    localparam logic signed [WW_IN-1:0] OUT_MAX = {{(WW_IN-WW_OUT+1){1'b0}}, {(WW_OUT-1){1'b1}}};
    localparam logic signed [WW_IN-1:0] OUT_MIN = {{(WW_IN-WW_OUT+1){1'b1}}, {(WW_OUT-1){1'b0}}};

    logic signed [WW_IN-1:0] shifted;

    assign shifted = din >>> SHIFT;

    always_comb begin
        dout = shifted[WW_OUT-1:0];
        sat  = 1'b0;
        if (shifted > OUT_MAX) begin
            dout = OUT_MAX[WW_OUT-1:0];
            sat  = 1'b1;
        end else if (shifted < OUT_MIN) begin
            dout = OUT_MIN[WW_OUT-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_tdm_prog.sv
// Time-multiplexed FIR with a runtime-programmable coefficient bank and a
// single shared MAC: one sample accepted, NTAPS MAC cycles, then one output.
module fir_tdm_prog
    import fir_tdm_prog_pkg::*;
#(
    parameter int WW_INPUT  = 8,
    parameter int WW_COEFF  = 8,
    parameter int WW_OUTPUT = 8,
    parameter int NTAPS     = 15,
    parameter int SHIFT     = 6
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic                          i_srst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [WW_INPUT-1:0]           i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [WW_OUTPUT-1:0]          o_data,
    output logic                          o_sat,
    input  logic                          i_coef_we,
    input  logic [fir_clog2(NTAPS)-1:0]   i_coef_addr,
    input  logic [WW_COEFF-1:0]           i_coef_data,
    output logic                          o_coef_err,
    output logic [1:0]                    o_state
);

    // Stream handshakes: a transfer happens on a rising edge where valid and
    // ready are both high; valid and payload are held stable until it does.

    localparam int AW      = fir_clog2(NTAPS);
    localparam int WW_PROD = WW_INPUT + WW_COEFF;
    localparam int WW_ACC  = fir_acc_width(WW_INPUT, WW_COEFF, NTAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
    localparam logic [AW:0]   NTAPS_W  = (AW+1)'(NTAPS);

    fir_state_t                 state;
    logic [AW-1:0]              idx;
    logic signed [WW_INPUT-1:0] taps  [NTAPS];
    logic signed [WW_COEFF-1:0] coefs [NTAPS];
    logic signed [WW_ACC-1:0]   acc;
    logic signed [WW_ACC-1:0]   acc_sum;
    logic signed [WW_PROD-1:0]  prod;
    logic [WW_OUTPUT-1:0]       sat_data;
    logic                       sat_flag;
    logic                       coef_ok;

    assign o_ready = (state == ST_IDLE);
    assign o_state = state;
    assign prod    = coefs[idx] * taps[idx];
    assign acc_sum = acc + {{(WW_ACC-WW_PROD){prod[WW_PROD-1]}}, prod};
    assign coef_ok = o_ready && ({1'b0, i_coef_addr} < NTAPS_W);

    // Fed from the running sum so the final product lands in the output
    // register on the same edge that ends the MAC phase.
    fir_sat_shift #(
        .WW_IN  (WW_ACC),
        .WW_OUT (WW_OUTPUT),
        .SHIFT  (SHIFT)
    ) u_sat_shift (
        .din  (acc_sum),
        .dout (sat_data),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            acc     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
        end else if (i_srst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            acc     <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        idx   <= '0;
                        acc   <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc_sum;
                    if (idx == LAST_IDX) begin
                        idx     <= '0;
                        o_data  <= sat_data;
                        o_sat   <= sat_flag;
                        o_valid <= 1'b1;
                        state   <= ST_OUT;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else if (i_srst) begin
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else if (i_valid && o_ready) begin
            for (int k = NTAPS - 1; k > 0; k--) taps[k] <= taps[k-1];
            taps[0] <= i_data;
        end
    end

    // Coefficients survive i_srst; only the async reset clears them.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) coefs[k] <= '0;
            o_coef_err <= 1'b0;
        end else begin
            o_coef_err <= 1'b0;
            if (i_coef_we) begin
                if (coef_ok) coefs[i_coef_addr] <= i_coef_data;
                else         o_coef_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_prog.sv
// Self-checking bench for fir_tdm_prog: vector tables plus a scoreboard fed
// by an independent integer model of the filter.
module tb_fir_tdm_prog;
    import fir_tdm_prog_pkg::*;

    localparam int NTAPS = 15;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_sat;
    } vec_t;

    // clock / reset
    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_srst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_sat;
    logic       i_coef_we;
    logic [3:0] i_coef_addr;
    logic [7:0] i_coef_data;
    logic       o_coef_err;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fir_tdm_prog #(
        .WW_INPUT(8), .WW_COEFF(8), .WW_OUTPUT(8), .NTAPS(NTAPS), .SHIFT(6)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_srst(i_srst),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat),
        .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
        .o_coef_err(o_coef_err), .o_state(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout or underflow at %0t", name, $time);
    endtask

    // scoreboard and reference model
    logic [8:0]        exp_q[$];
    logic signed [7:0] mtaps [NTAPS];
    logic signed [7:0] mcoef [NTAPS];
    time               acc_times[$];

    function automatic logic [8:0] model_out();
        int acc;
        int sh;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc += int'(mcoef[k]) * int'(mtaps[k]);
        sh = acc >>> 6;
        if (sh > 127)  return {1'b1, 8'h7F};
        if (sh < -128) return {1'b1, 8'h80};
        return {1'b0, sh[7:0]};
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                mtaps[k] = '0;
                mcoef[k] = '0;
            end
            exp_q.delete();
        end else begin
            if (i_coef_we && o_ready && int'(i_coef_addr) < NTAPS)
                mcoef[i_coef_addr] = i_coef_data;
            if (i_srst) begin
                for (int k = 0; k < NTAPS; k++) mtaps[k] = '0;
                exp_q.delete();
            end else begin
                if (i_valid && o_ready) begin
                    for (int k = NTAPS - 1; k > 0; k--) mtaps[k] = mtaps[k-1];
                    mtaps[0] = i_data;
                    exp_q.push_back(model_out());
                    acc_times.push_back($time);
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) fail("sb_underflow");
                    else check("sb_out", 32'({o_sat, o_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic send(input logic [7:0] d, input bit scramble);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = d;
        while (!o_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (scramble) i_data = 8'($urandom_range(0, 255));
        end
        if (!o_ready) fail("send_ready");
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_valid) fail("wait_valid");
    endtask

    task automatic get_out(output logic [7:0] d, output logic s);
        wait_valid();
        d = o_data;
        s = o_sat;
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
        i_coef_we   = 1'b1;
        i_coef_addr = a;
        i_coef_data = d;
        @(negedge clk);
        i_coef_we = 1'b0;
    endtask

    task automatic program_ramp();
        for (int k = 0; k < NTAPS; k++) write_coef(4'(k), 8'(k + 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs [46];

    task automatic run_vectors(input int lo, input int hi);
        logic [7:0] d;
        logic       s;
        for (int i = lo; i <= hi; i++) begin
            send(vecs[i].din, 1'b0);
            get_out(d, s);
            check($sformatf("vec%0d", i), 32'({s, d}), 32'({vecs[i].exp_sat, vecs[i].exp_data}));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, cap_d;
        logic       s, cap_s;
        bit         done;

        // impulse of 64 with SHIFT=6 gives coef[k] back; saturation phase
        // flips sign once eight of fifteen taps hold -128.
        for (int i = 0; i < 16; i++)
            vecs[i] = '{din: (i == 0) ? 8'd64 : 8'd0, exp_data: (i < 15) ? 8'(i + 1) : 8'd0, exp_sat: 1'b0};
        for (int j = 0; j < 15; j++) begin
            vecs[16+j] = '{din: 8'h7F, exp_data: 8'h7F, exp_sat: 1'b1};
            vecs[31+j] = '{din: 8'h80, exp_data: (j + 1 <= 7) ? 8'h7F : 8'h80, exp_sat: 1'b1};
        end

        i_rst_n = 1'b0; i_srst = 1'b0; i_valid = 1'b0; i_data = '0;
        i_ready = 1'b1; i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
        #3;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_sat", 32'(o_sat), 32'd0);
        check("rst_coef_err", 32'(o_coef_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        #19 i_rst_n = 1'b1;
        @(negedge clk);

        // impulse response
        program_ramp();
        run_vectors(0, 15);

        // saturation both rails
        for (int k = 0; k < NTAPS; k++) write_coef(4'(k), 8'h7F);
        run_vectors(16, 45);

        // throughput with valid held and ready high
        acc_times.delete();
        i_valid = 1'b1;
        i_data  = 8'h11;
        for (int n = 0; n < 200 && acc_times.size() < 4; n++) @(negedge clk);
        i_valid = 1'b0;
        if (acc_times.size() < 4) fail("throughput_wait");
        else for (int i = 1; i < 4; i++)
            check("throughput", 32'(acc_times[i] - acc_times[i-1]), 32'(10 * (NTAPS + 2)));
        drain();

        // fixed five-cycle stall in OUT
        i_ready = 1'b0;
        send(8'h25, 1'b0);
        wait_valid();
        cap_d = o_data;
        cap_s = o_sat;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_data", 32'({o_sat, o_data}), 32'({cap_s, cap_d}));
            check("stall_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        drain();

        // 100 random samples under random backpressure and random coefficients
        for (int k = 0; k < NTAPS; k++) write_coef(4'(k), 8'($urandom_range(0, 255)));
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) send(8'($urandom_range(0, 255)), 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        drain();

        // coefficient write rejected while busy, and out-of-range address
        send(8'h40, 1'b0);
        write_coef(4'd3, 8'h55);
        check("coef_err_busy", 32'(o_coef_err), 32'd1);
        @(negedge clk);
        check("coef_err_pulse", 32'(o_coef_err), 32'd0);
        drain();
        write_coef(4'(NTAPS), 8'h12);
        check("coef_err_addr", 32'(o_coef_err), 32'd1);
        @(negedge clk);
        check("coef_err_clear", 32'(o_coef_err), 32'd0);
        write_coef(4'd2, 8'h21);
        check("coef_ok_idle", 32'(o_coef_err), 32'd0);

        // coefficient write and sample handshake in the same cycle
        i_coef_we = 1'b1; i_coef_addr = 4'd0; i_coef_data = 8'hC3;
        send(8'h5A, 1'b0);
        i_coef_we = 1'b0;
        check("coef_same_cycle_err", 32'(o_coef_err), 32'd0);
        drain();

        // async reset mid-MAC: outputs drop without a clock edge
        send(8'h33, 1'b0);
        @(negedge clk);
        #3 i_rst_n = 1'b0;
        #1;
        check("arst_o_valid", 32'(o_valid), 32'd0);
        check("arst_o_ready", 32'(o_ready), 32'd1);
        check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        #4 i_rst_n = 1'b1;
        @(negedge clk);
        send(8'h7F, 1'b0);
        get_out(d, s);
        check("arst_coefs_zero", 32'({s, d}), 32'd0);

        // sync clear mid-OUT keeps the coefficient bank
        program_ramp();
        i_ready = 1'b0;
        send(8'd64, 1'b0);
        wait_valid();
        i_srst = 1'b1;
        @(negedge clk);
        i_srst = 1'b0;
        check("srst_o_valid", 32'(o_valid), 32'd0);
        check("srst_o_ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        run_vectors(0, 15);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
